// File: rtl/conv_window_gen_3x3.sv
// 3x3 convolution window generator.
// Accepts one raster-order pixel per valid cycle, keeps the two previous image
// rows in column-addressed line buffers, and emits every fully-populated 3x3
// window (valid convolution, no padding) as one packed word for the MAC stage.
// Packed order: [9W-1 -: W] = p1_1 (oldest row, leftmost col) ... [W-1:0] = p3_3.
module conv_window_gen_3x3 #(
  parameter int WT_BITS = 16,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WT_BITS-1:0]     pix_in,
  input  logic                   pix_valid,
  output logic [9*WT_BITS-1:0]   ifmap_chunk,
  output logic                   win_valid,
  output logic                   frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Raster position of the pixel presented on pix_in.
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  // Line buffers addressed by column: entry c holds the most recent pixel of
  // that column from one row back (lb1) and two rows back (lb2). Reading and
  // writing the same column slot each valid cycle behaves exactly like an
  // IMG_W-deep shift register without moving every entry.
  logic [WT_BITS-1:0] lb1_mem [IMG_W];
  logic [WT_BITS-1:0] lb2_mem [IMG_W];
  logic [WT_BITS-1:0] lb1_out;
  logic [WT_BITS-1:0] lb2_out;

  // Window registers: win[row][col], row 0 = oldest, col 0 = leftmost.
  logic [WT_BITS-1:0] win      [3][3];
  logic [WT_BITS-1:0] win_next [3][3];
  logic [9*WT_BITS-1:0] packed_next;

  logic completes;
  logic last_pix;

  // Line buffer read ports at the current column.
  always_comb begin
    lb1_out = lb1_mem[col_cnt];
    lb2_out = lb2_mem[col_cnt];
  end

  // Window contents after accepting the current pixel: shift left, load new right column.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      win_next[i][0] = win[i][1];
      win_next[i][1] = win[i][2];
    end
    win_next[0][2] = lb2_out;
    win_next[1][2] = lb1_out;
    win_next[2][2] = pix_in;
  end

  // Pack the next window into MAC field order, p1_1 in the top field.
  always_comb begin
    packed_next = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        packed_next[(8 - (3*i + j))*WT_BITS +: WT_BITS] = win_next[i][j];
      end
    end
  end

  // Window completion and end-of-frame decode for the pixel being accepted.
  always_comb begin
    completes = pix_valid && (row_cnt >= ROW_TWO) && (col_cnt >= COL_TWO);
    last_pix  = pix_valid && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
  end

  // Raster counters: column wraps into row, row wraps into the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (pix_valid) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Line buffer update; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1_mem[col_cnt] <= pix_in;
      lb2_mem[col_cnt] <= lb1_out;
    end
  end

  // Window register shift on every accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        for (int unsigned j = 0; j < 3; j++) begin
          win[i][j] <= '0;
        end
      end
    end else if (pix_valid) begin
      for (int unsigned i = 0; i < 3; i++) begin
        for (int unsigned j = 0; j < 3; j++) begin
          win[i][j] <= win_next[i][j];
        end
      end
    end
  end

  // Registered outputs: window word loads only on completion and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifmap_chunk <= '0;
      win_valid   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      win_valid  <= completes;
      frame_done <= last_pix;
      if (completes) begin
        ifmap_chunk <= packed_next;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Testbench for conv_window_gen_3x3: default 28x28 instance plus a 4x3 instance,
// compared against an image-array reference model.
module tb_conv_window_gen_3x3;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int SW = 4;
  localparam int SH = 3;

  localparam logic [143:0] LIT_FIRST = {16'd0, 16'd1, 16'd2, 16'd28, 16'd29, 16'd30,
                                        16'd56, 16'd57, 16'd58};
  localparam logic [143:0] LIT_LAST  = {16'd725, 16'd726, 16'd727, 16'd753, 16'd754,
                                        16'd755, 16'd781, 16'd782, 16'd783};
  localparam logic [143:0] LIT_F2    = {16'd1000, 16'd1001, 16'd1002, 16'd1028, 16'd1029,
                                        16'd1030, 16'd1056, 16'd1057, 16'd1058};
  localparam logic [143:0] LIT_S1    = {16'd0, 16'd1, 16'd2, 16'd4, 16'd5, 16'd6,
                                        16'd8, 16'd9, 16'd10};
  localparam logic [143:0] LIT_S2    = {16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7,
                                        16'd9, 16'd10, 16'd11};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  pix_in = '0;
  logic         pix_valid = 1'b0;
  logic [143:0] ifmap_chunk;
  logic         win_valid;
  logic         frame_done;

  logic [15:0]  s_pix = '0;
  logic         s_valid = 1'b0;
  logic [143:0] s_chunk;
  logic         s_win_valid;
  logic         s_frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model state (default instance).
  logic [15:0]  img [H][W];
  logic [143:0] exp_chunk = '0;
  int           n = 0;
  int           cur_base = 0;
  int           win_cnt = 0;
  int           done_cnt = 0;

  // Reference model state (small instance).
  logic [15:0]  simg [SH][SW];
  logic [143:0] s_exp_chunk = '0;
  int           sk = 0;
  bit           s_ramp = 1'b0;
  int           s_win_cnt = 0;
  int           s_done_cnt = 0;

  always #5 clk = ~clk;

  conv_window_gen_3x3 #(.WT_BITS(16), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .ifmap_chunk(ifmap_chunk), .win_valid(win_valid), .frame_done(frame_done)
  );

  conv_window_gen_3x3 #(.WT_BITS(16), .IMG_W(SW), .IMG_H(SH)) dut_s (
    .clk(clk), .rst(rst), .pix_in(s_pix), .pix_valid(s_valid),
    .ifmap_chunk(s_chunk), .win_valid(s_win_valid), .frame_done(s_frame_done)
  );

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock on the default instance; model updated from raster rules, outputs checked.
  task automatic step(input logic v, input logic [15:0] p);
    int  r, c;
    logic ev, ed;
    @(negedge clk);
    pix_valid = v;
    pix_in    = p;
    @(posedge clk);
    #1;
    ev = 1'b0;
    ed = 1'b0;
    r  = n / W;
    c  = n % W;
    if (v) begin
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        ev = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_chunk[(8 - (3*i + j))*16 +: 16] = img[r-2+i][c-2+j];
      end
      ed = (n == W*H - 1);
      n  = (n + 1) % (W*H);
    end
    chk("win_valid", {143'b0, win_valid}, {143'b0, ev});
    chk("frame_done", {143'b0, frame_done}, {143'b0, ed});
    chk("ifmap_chunk", ifmap_chunk, exp_chunk);
    if (v && r == 2 && c == 2 && cur_base == 0)     chk("first_win", ifmap_chunk, LIT_FIRST);
    if (v && r == 2 && c == 2 && cur_base == 1000)  chk("f2_first_win", ifmap_chunk, LIT_F2);
    if (v && r == H-1 && c == W-1 && cur_base == 0) chk("last_win", ifmap_chunk, LIT_LAST);
    if (win_valid) win_cnt++;
    if (frame_done) begin
      chk("frame_windows", 144'(win_cnt), 144'((H-2)*(W-2)));
      win_cnt = 0;
      done_cnt++;
    end
  endtask

  // Send one pixel, preceded by random idle cycles with junk data when gap_pct > 0.
  task automatic send(input logic [15:0] p, input int gap_pct);
    while ($urandom_range(0, 99) < gap_pct) step(1'b0, 16'($urandom));
    step(1'b1, p);
  endtask

  task automatic step_s(input logic v, input logic [15:0] p);
    int  r, c;
    logic ev, ed;
    @(negedge clk);
    s_valid = v;
    s_pix   = p;
    @(posedge clk);
    #1;
    ev = 1'b0;
    ed = 1'b0;
    r  = sk / SW;
    c  = sk % SW;
    if (v) begin
      simg[r][c] = p;
      if (r >= 2 && c >= 2) begin
        ev = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s_exp_chunk[(8 - (3*i + j))*16 +: 16] = simg[r-2+i][c-2+j];
      end
      ed = (sk == SW*SH - 1);
      sk = (sk + 1) % (SW*SH);
    end
    chk("s_win_valid", {143'b0, s_win_valid}, {143'b0, ev});
    chk("s_frame_done", {143'b0, s_frame_done}, {143'b0, ed});
    chk("s_chunk", s_chunk, s_exp_chunk);
    if (v && ev && s_ramp && c == 2) chk("s_win1", s_chunk, LIT_S1);
    if (v && ev && s_ramp && c == 3) chk("s_win2", s_chunk, LIT_S2);
    if (s_win_valid) s_win_cnt++;
    if (s_frame_done) s_done_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    pix_valid = 1'b0;
    s_valid   = 1'b0;
    #1;
    chk("rst_chunk", ifmap_chunk, '0);
    chk("rst_win_valid", {143'b0, win_valid}, '0);
    chk("rst_frame_done", {143'b0, frame_done}, '0);
    chk("rst_s_chunk", s_chunk, '0);
    n = 0; exp_chunk = '0; win_cnt = 0;
    sk = 0; s_exp_chunk = '0;
    repeat (2) @(negedge clk);
    chk("rst_hold_chunk", ifmap_chunk, '0);
    chk("rst_hold_win_valid", {143'b0, win_valid}, '0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Gap-free ramp frame.
    cur_base = 0;
    for (int k = 0; k < W*H; k++) send(16'((k / W)*W + k % W), 0);
    chk("win_cnt_after_f1", 144'(win_cnt), '0);

    // Same ramp with ~50% idle cycles.
    for (int k = 0; k < W*H; k++) send(16'(k), 50);

    // Back-to-back second frame offset by 1000.
    cur_base = 1000;
    for (int k = 0; k < W*H; k++) send(16'(1000 + k), 0);

    // Random pixel values with gaps.
    cur_base = -1;
    for (int k = 0; k < W*H; k++) send(16'($urandom), 50);

    // Partial frame interrupted by reset, then a full ramp frame.
    for (int k = 0; k < 400; k++) send(16'($urandom), 20);
    do_reset();
    cur_base = 0;
    for (int k = 0; k < W*H; k++) send(16'(k), 0);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("frame_done_count", 144'(done_cnt), 144'(5));

    // Small 4x3 instance: ramp, then negative values with gaps.
    s_ramp = 1'b1;
    for (int k = 0; k < SW*SH; k++) step_s(1'b1, 16'(k));
    s_ramp = 1'b0;
    for (int k = 0; k < SW*SH; k++) begin
      if ($urandom_range(0, 1) == 1) step_s(1'b0, 16'($urandom));
      step_s(1'b1, 16'hFFFF - 16'(k));
    end
    step_s(1'b0, '0);
    chk("s_window_count", 144'(s_win_cnt), 144'(4));
    chk("s_done_count", 144'(s_done_cnt), 144'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
